sha_work_scheduler: RTL and testbench
=====================================

Name: sha_work_scheduler

Overview:
Sequences one double-SHA256 mining pipeline (the sha_hasher core) through a job.
- Accepts a job descriptor over a valid/ready handshake.
- Loads the hasher by pulsing its active-low load/reset, then runs it over a bounded nonce range and drains the pipeline.
- Maps each hit back to its {time,nonce} using the known pipeline latency, and presents solutions over a valid/ready output.
- Sits between the host-interface block and the hasher.

Parameters:
PIPE_LAT, 128, cycles of hs_write_en between issuing a nonce and its hs_valid/hs_hit result
DROP_W, 8, width of the saturating dropped-solution counter

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-low reset
job_valid  in  1  job descriptor valid
job_ready  out  1  scheduler accepts job
job_abort  in  1  abandon current job; sampled in LOAD/RUN/DRAIN
job_midstate  in  256  midstate for hasher digest_in
job_digest_init  in  256  initial digest for hasher digest_intial
job_merkle  in  32  merkle tail word
job_time  in  32  start time
job_target  in  32  compact target (nBits)
job_nonce  in  32  start nonce
job_count  in  32  nonces to try; 0 means 2^32
hs_rst_n  out  1  hasher load/reset, active-low
hs_write_en  out  1  hasher advance enable
hs_digest_init  out  256  registered job_digest_init
hs_digest_in  out  256  registered job_midstate
hs_merkle  out  32  registered
hs_time  out  32  registered start time
hs_target  out  32  registered
hs_nonce  out  32  registered start nonce
hs_valid  in  1  hasher output valid
hs_hit  in  1  hasher result below target; qualified by hs_valid
sol_valid  out  1  solution available
sol_ready  in  1  consumer takes solution
sol_time  out  32  solution time
sol_nonce  out  32  solution nonce
busy  out  1  state != IDLE
job_done  out  1  one-cycle pulse on range completion (not on abort)
drop_cnt  out  DROP_W  hits lost because the solution slot was full; saturating

Behaviour:
- Reset values: all outputs 0, except hs_rst_n=0 (hasher held in reset) and job_ready=1. State=IDLE.
- FSM states: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE: job_ready=1, hs_rst_n=0, hs_write_en=0.
  - On job_valid: latch all job_* fields into the hs_* registers.
  - Set remaining = (job_count==0) ? 2^32 : job_count (33-bit).
  - Set res_ctr = {job_time,job_nonce} (64-bit), fill = 0. Go to LOAD.
- LOAD: exactly 1 cycle with hs_rst_n=0, so the hasher latches its inputs. Then RUN.
- RUN: hs_rst_n=1, hs_write_en=1, remaining decrements every cycle. When remaining reaches 1 this cycle, go to DRAIN. A job therefore has exactly remaining cycles of write_en in RUN.
- DRAIN: hs_write_en=1 for PIPE_LAT - 1 further cycles (drain counter), then DONE.
- DONE: 1 cycle; job_done=1, hs_rst_n=0. Then IDLE.
- Result tracking, in every cycle with hs_write_en=1:
  - If fill < PIPE_LAT: fill++.
  - Else: the result being presented corresponds to res_ctr.
    - Hit accepted if hs_valid & hs_hit.
    - res_ctr++ after the check.
  - res_ctr is 64-bit {time,nonce}; a nonce wrap from FFFFFFFF carries into time, matching the hasher counter.
  - Hits are counted only for the first N results of the job (N = original remaining); results after N are ignored.
- Solution slot: single entry.
  - Accepted hit with slot empty (or emptied this cycle by sol_valid&sol_ready): load {sol_time,sol_nonce}=res_ctr, sol_valid=1.
  - Accepted hit with slot full and not draining: drop_cnt++ (saturate at all-ones), slot unchanged.
  - sol_valid drops on sol_ready when no new hit arrives.
  - The slot survives abort and job completion. drop_cnt clears only on reset.
- Abort: job_abort in LOAD/RUN/DRAIN.
  - Next cycle: hs_write_en=0, hs_rst_n=0, in-flight results discarded, fill=0.
  - No job_done pulse. Go to IDLE.
  - Abort and job_valid in the same cycle in IDLE: job_valid wins; abort is ignored in IDLE.
- Asynchronous RST mid-job: immediate return to reset values, solution slot cleared.

Decomposition:
- Package sha_sched_pkg holds:
  - state enum encoding (IDLE=0, LOAD=1, RUN=2, DRAIN=3, DONE=4)
  - PIPE_LAT default
  - 64-bit {time,nonce} counter width constant
- One natural sub-module: sha_sol_slot, the single-entry valid/ready holding register plus the saturating drop counter.

Test Plan:
- PIPE_LAT=4, job nonce=0x10, count=8, hs_valid=1 on every write_en cycle after 4 fills, hs_hit at the 3rd result -> sol_nonce=0x12, sol_time=job_time, job_done after 1+8+3 cycles from LOAD, 11 write_en cycles total.
- nonce=0xFFFFFFFE, time=0x5, count=4, hit on the 3rd result -> sol_time=0x6, sol_nonce=0x00000000.
- Two hits on consecutive results with sol_ready=0 -> first held (sol_valid=1), drop_cnt=1; raise sol_ready -> sol_valid=0 next cycle.
- job_abort asserted 2 cycles into RUN -> hs_rst_n=0 and hs_write_en=0 next cycle, no job_done, job_ready=1, following job starts with fill=0.
- count=0 with PIPE_LAT=4 -> RUN lasts 2^32 cycles (check the remaining counter via fast-forward force) and no early DRAIN.
- RST pulsed low during DRAIN with sol_valid=1 -> all outputs at reset values, sol_valid=0, drop_cnt=0.

Source files
------------

// File: rtl/sha_sched_pkg.sv
// Shared types and constants for the double-SHA256 work scheduler.
package sha_sched_pkg;

    localparam int PIPE_LAT_DEF = 128;
    localparam int CTR_W        = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/sha_sol_slot.sv
// Single-entry solution holding register with valid/ready output and a
// saturating counter of hits lost while the entry was occupied.
module sha_sol_slot
    import sha_sched_pkg::*;
#(
    parameter int DROP_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_hit,
    input  logic [CTR_W-1:0]  i_res,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [CTR_W-1:0]  o_data,
    output logic [DROP_W-1:0] o_drop_cnt
);

    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);
    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    logic              r_valid;
    logic [CTR_W-1:0]  r_data;
    logic [DROP_W-1:0] r_drop;
    logic              w_take;

    assign w_take = r_valid & i_ready;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_drop  <= '0;
        end else if (i_hit) begin
            // an entry being consumed this cycle frees the slot for the new hit
            if (!r_valid || w_take) begin
                r_valid <= 1'b1;
                r_data  <= i_res;
            end else if (r_drop != DROP_MAX) begin
                r_drop <= r_drop + DROP_ONE;
            end
        end else if (w_take) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_drop_cnt = r_drop;

endmodule

// File: rtl/sha_work_scheduler.sv
// Sequences one sha_hasher pipeline through a job: load, run a nonce range,
// drain, and map hits back to {time,nonce} using the known pipeline latency.
//   state | meaning
//   IDLE  | job_ready, hasher held in reset
//   LOAD  | one cycle in reset so the hasher latches the job
//   RUN   | write_en, one nonce per cycle until the range is exhausted
//   DRAIN | write_en for PIPE_LAT-1 more cycles to flush results
//   DONE  | one-cycle job_done pulse
module sha_work_scheduler
    import sha_sched_pkg::*;
#(
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int DROP_W   = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic              job_abort,
    input  logic [255:0]      job_midstate,
    input  logic [255:0]      job_digest_init,
    input  logic [31:0]       job_merkle,
    input  logic [31:0]       job_time,
    input  logic [31:0]       job_target,
    input  logic [31:0]       job_nonce,
    input  logic [31:0]       job_count,
    output logic              hs_rst_n,
    output logic              hs_write_en,
    output logic [255:0]      hs_digest_init,
    output logic [255:0]      hs_digest_in,
    output logic [31:0]       hs_merkle,
    output logic [31:0]       hs_time,
    output logic [31:0]       hs_target,
    output logic [31:0]       hs_nonce,
    input  logic              hs_valid,
    input  logic              hs_hit,
    output logic              sol_valid,
    input  logic              sol_ready,
    output logic [31:0]       sol_time,
    output logic [31:0]       sol_nonce,
    output logic              busy,
    output logic              job_done,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int          FILL_W = $clog2(PIPE_LAT + 1);
    localparam logic [32:0] TWO32  = 33'h1_0000_0000;

    state_t             r_state;
    logic [32:0]        r_remaining;
    logic [32:0]        r_res_left;
    logic [CTR_W-1:0]   r_res_ctr;
    logic [FILL_W-1:0]  r_fill;
    logic [FILL_W-1:0]  r_drain;

    logic               w_wen;
    logic               w_accept;
    logic               w_abort;
    logic               w_full;
    logic               w_hit;
    logic [32:0]        w_job_n;
    logic [CTR_W-1:0]   w_sol_data;

    assign w_wen    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_accept = (r_state == ST_IDLE) && job_valid;
    assign w_abort  = job_abort && (r_state inside {ST_LOAD, ST_RUN, ST_DRAIN});
    assign w_full   = (r_fill == FILL_W'(PIPE_LAT));
    assign w_job_n  = (job_count == 32'd0) ? TWO32 : {1'b0, job_count};
    assign w_hit    = w_wen && w_full && hs_valid && hs_hit && (r_res_left != 33'd0);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state        <= ST_IDLE;
            r_remaining    <= '0;
            r_drain        <= '0;
            hs_digest_init <= '0;
            hs_digest_in   <= '0;
            hs_merkle      <= '0;
            hs_time        <= '0;
            hs_target      <= '0;
            hs_nonce       <= '0;
        end else if (w_abort) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (job_valid) begin
                    hs_digest_init <= job_digest_init;
                    hs_digest_in   <= job_midstate;
                    hs_merkle      <= job_merkle;
                    hs_time        <= job_time;
                    hs_target      <= job_target;
                    hs_nonce       <= job_nonce;
                    r_remaining    <= w_job_n;
                    r_state        <= ST_LOAD;
                end
                ST_LOAD: r_state <= ST_RUN;
                ST_RUN: begin
                    r_remaining <= r_remaining - 33'd1;
                    if (r_remaining == 33'd1) begin
                        r_drain <= FILL_W'(PIPE_LAT - 1);
                        r_state <= (PIPE_LAT > 1) ? ST_DRAIN : ST_DONE;
                    end
                end
                ST_DRAIN: begin
                    r_drain <= r_drain - FILL_W'(1);
                    if (r_drain == FILL_W'(1)) r_state <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // results only start emerging once PIPE_LAT enabled cycles have filled the pipe
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_fill     <= '0;
            r_res_ctr  <= '0;
            r_res_left <= '0;
        end else if (w_accept) begin
            r_fill     <= '0;
            r_res_ctr  <= {job_time, job_nonce};
            r_res_left <= w_job_n;
        end else if (w_abort) begin
            r_fill <= '0;
        end else if (w_wen) begin
            if (!w_full) begin
                r_fill <= r_fill + FILL_W'(1);
            end else begin
                r_res_ctr <= r_res_ctr + 64'd1;
                if (r_res_left != 33'd0) r_res_left <= r_res_left - 33'd1;
            end
        end
    end

    sha_sol_slot #(.DROP_W(DROP_W)) u_slot (
        .CLK        (CLK),
        .RST        (RST),
        .i_hit      (w_hit),
        .i_res      (r_res_ctr),
        .i_ready    (sol_ready),
        .o_valid    (sol_valid),
        .o_data     (w_sol_data),
        .o_drop_cnt (drop_cnt)
    );

    assign sol_time    = w_sol_data[63:32];
    assign sol_nonce   = w_sol_data[31:0];
    assign job_ready   = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign job_done    = (r_state == ST_DONE);
    assign hs_rst_n    = w_wen;
    assign hs_write_en = w_wen;

endmodule

// File: tb/tb_sha_work_scheduler.sv
// Bench for sha_work_scheduler: drives a fake hasher and checks solutions
// against a job-level model of nonce ranges and the single-entry slot.
`timescale 1ns/1ps
module tb_sha_work_scheduler;

    localparam int          PL    = 4;
    localparam logic [32:0] TWO32 = 33'h1_0000_0000;

    logic         CLK = 1'b0;
    logic         RST;
    logic         job_valid, job_ready, job_abort;
    logic [255:0] job_midstate, job_digest_init;
    logic [31:0]  job_merkle, job_time, job_target, job_nonce, job_count;
    logic         hs_rst_n, hs_write_en;
    logic [255:0] hs_digest_init, hs_digest_in;
    logic [31:0]  hs_merkle, hs_time, hs_target, hs_nonce;
    logic         hs_valid, hs_hit;
    logic         sol_valid, sol_ready;
    logic [31:0]  sol_time, sol_nonce;
    logic         busy, job_done;
    logic [7:0]   drop_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // job-level reference model
    logic        m_sol_v;
    logic [63:0] m_sol;
    int          m_drop;
    logic [63:0] m_start;
    longint      m_n;
    int          wen_cycles, res_seen, since_load, done_at;
    bit          hit_at[int];

    always #5 CLK = ~CLK;

    sha_work_scheduler #(.PIPE_LAT(PL), .DROP_W(8)) dut (
        .CLK(CLK), .RST(RST),
        .job_valid(job_valid), .job_ready(job_ready), .job_abort(job_abort),
        .job_midstate(job_midstate), .job_digest_init(job_digest_init),
        .job_merkle(job_merkle), .job_time(job_time), .job_target(job_target),
        .job_nonce(job_nonce), .job_count(job_count),
        .hs_rst_n(hs_rst_n), .hs_write_en(hs_write_en),
        .hs_digest_init(hs_digest_init), .hs_digest_in(hs_digest_in),
        .hs_merkle(hs_merkle), .hs_time(hs_time), .hs_target(hs_target),
        .hs_nonce(hs_nonce), .hs_valid(hs_valid), .hs_hit(hs_hit),
        .sol_valid(sol_valid), .sol_ready(sol_ready),
        .sol_time(sol_time), .sol_nonce(sol_nonce),
        .busy(busy), .job_done(job_done), .drop_cnt(drop_cnt)
    );

    // One clock: acts as the hasher for this cycle, advances the model, then
    // returns at the next falling edge where outputs are sampled.
    task automatic step();
        bit          acc;
        bit          take;
        logic [63:0] rv;
        acc = 1'b0;
        rv  = '0;
        if (hs_write_en) wen_cycles++;
        if (hs_write_en && wen_cycles > PL) begin
            res_seen++;
            if (hit_at.exists(res_seen)) begin
                hs_valid = 1'b1;
                hs_hit   = 1'b1;
            end else begin
                hs_valid = 1'($urandom_range(0, 1));
                hs_hit   = hs_valid ? 1'b0 : 1'($urandom_range(0, 1));
            end
            if (hs_valid && hs_hit && res_seen <= m_n) begin
                acc = 1'b1;
                rv  = m_start + 64'(res_seen - 1);
            end
        end else begin
            hs_valid = 1'($urandom_range(0, 1));
            hs_hit   = 1'($urandom_range(0, 1));
        end
        take = m_sol_v && sol_ready;
        if (acc) begin
            if (!m_sol_v || take) begin
                m_sol_v = 1'b1;
                m_sol   = rv;
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end else if (take) begin
            m_sol_v = 1'b0;
        end
        if (job_done) done_at = since_load;
        since_load++;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic start_job(input logic [31:0] t, input logic [31:0] n, input logic [31:0] c);
        job_time        = t;
        job_nonce       = n;
        job_count       = c;
        job_merkle      = $urandom;
        job_target      = $urandom;
        for (int i = 0; i < 8; i++) begin
            job_midstate[i*32 +: 32]    = $urandom;
            job_digest_init[i*32 +: 32] = $urandom;
        end
        m_start    = {t, n};
        m_n        = (c == 0) ? 64'h1_0000_0000 : longint'(c);
        wen_cycles = 0;
        res_seen   = 0;
        since_load = -1;
        done_at    = -1;
        hit_at.delete();
        job_valid  = 1'b1;
        step();
        job_valid  = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        for (int i = 0; i < bound && done_at < 0; i++) step();
        ok = (done_at >= 0);
    endtask

    task automatic test_reset();
        RST = 1'b0; job_valid = 1'b0; job_abort = 1'b0; sol_ready = 1'b0;
        hs_valid = 1'b0; hs_hit = 1'b0;
        job_midstate = '0; job_digest_init = '0; job_merkle = '0; job_time = '0;
        job_target = '0; job_nonce = '0; job_count = '0;
        m_sol_v = 1'b0; m_sol = '0; m_drop = 0; done_at = -1; since_load = 0;
        #1;
        n_cmp++;
        if ({job_ready, hs_rst_n, hs_write_en, busy, job_done, sol_valid} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 100000",
                     {job_ready, hs_rst_n, hs_write_en, busy, job_done, sol_valid});
        end
        n_cmp++;
        if ({hs_digest_init, hs_digest_in, hs_merkle, hs_time, hs_target, hs_nonce,
             sol_time, sol_nonce, drop_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: nonzero data outputs hs_nonce=%h sol_nonce=%h drop=%0d",
                     hs_nonce, sol_nonce, drop_cnt);
        end
        @(negedge CLK); @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_basic();
        bit ok;
        logic [31:0] t;
        t = $urandom;
        sol_ready = 1'b0;
        start_job(t, 32'h10, 32'd8);
        hit_at[3] = 1'b1;
        wait_done(40, ok);
        n_cmp++;
        if (!ok || done_at != 12) begin
            n_fail++; $display("FAIL basic_done_at: got %0d want 12", done_at);
        end
        n_cmp++;
        if (wen_cycles != 11) begin
            n_fail++; $display("FAIL basic_wen_cycles: got %0d want 11", wen_cycles);
        end
        n_cmp++;
        if ({hs_digest_init, hs_digest_in, hs_merkle, hs_time, hs_target, hs_nonce} !==
            {job_digest_init, job_midstate, job_merkle, t, job_target, 32'h10}) begin
            n_fail++; $display("FAIL basic_hs_regs: got nonce %h time %h want %h %h",
                               hs_nonce, hs_time, 32'h10, t);
        end
        n_cmp++;
        if ({sol_valid, sol_time, sol_nonce} !== {1'b1, t, 32'h12}) begin
            n_fail++; $display("FAIL basic_sol: got %b %h %h want 1 %h 00000012",
                               sol_valid, sol_time, sol_nonce, t);
        end
        sol_ready = 1'b1;
        step();
        sol_ready = 1'b0;
        n_cmp++;
        if (sol_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_consume: got sol_valid %b want 0", sol_valid);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        start_job(32'h5, 32'hFFFF_FFFE, 32'd4);
        hit_at[3] = 1'b1;
        wait_done(40, ok);
        n_cmp++;
        if (!ok || done_at != 8) begin
            n_fail++; $display("FAIL wrap_done_at: got %0d want 8", done_at);
        end
        n_cmp++;
        if ({sol_valid, sol_time, sol_nonce} !== {1'b1, 32'h6, 32'h0}) begin
            n_fail++; $display("FAIL wrap_sol: got %b %h %h want 1 00000006 00000000",
                               sol_valid, sol_time, sol_nonce);
        end
        sol_ready = 1'b1;
        step();
        sol_ready = 1'b0;
    endtask

    task automatic test_drop();
        bit ok;
        logic [31:0] t, n;
        t = $urandom; n = $urandom_range(0, 32'h7FFF_FFFF);
        start_job(t, n, 32'd8);
        hit_at[2] = 1'b1;
        hit_at[3] = 1'b1;
        wait_done(40, ok);
        n_cmp++;
        if ({sol_valid, sol_time, sol_nonce} !== {1'b1, t, n + 32'd1}) begin
            n_fail++; $display("FAIL drop_held: got %b %h %h want 1 %h %h",
                               sol_valid, sol_time, sol_nonce, t, n + 32'd1);
        end
        n_cmp++;
        if (drop_cnt !== 8'd1) begin
            n_fail++; $display("FAIL drop_cnt: got %0d want 1", drop_cnt);
        end
        sol_ready = 1'b1;
        step();
        sol_ready = 1'b0;
        n_cmp++;
        if (sol_valid !== 1'b0) begin
            n_fail++; $display("FAIL drop_release: got sol_valid %b want 0", sol_valid);
        end
    endtask

    task automatic test_abort();
        bit ok;
        bit saw_done;
        logic [31:0] t, n;
        start_job($urandom, $urandom, 32'd20);
        while (since_load < 2) step();
        job_abort = 1'b1;
        step();
        job_abort = 1'b0;
        n_cmp++;
        if ({hs_rst_n, hs_write_en, job_ready, busy} !== 4'b0010) begin
            n_fail++; $display("FAIL abort_ctrl: got %b want 0010",
                               {hs_rst_n, hs_write_en, job_ready, busy});
        end
        saw_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (job_done) saw_done = 1'b1;
            step();
        end
        n_cmp++;
        if (saw_done || done_at >= 0) begin
            n_fail++; $display("FAIL abort_no_done: got job_done pulse want none");
        end
        // abort raised together with job_valid in IDLE must not cancel the job
        t = $urandom; n = $urandom;
        job_abort = 1'b1;
        start_job(t, n, 32'd6);
        job_abort = 1'b0;
        hit_at[1] = 1'b1;
        wait_done(40, ok);
        n_cmp++;
        if (!ok || done_at != 10) begin
            n_fail++; $display("FAIL abort_next_done: got %0d want 10", done_at);
        end
        n_cmp++;
        if ({sol_valid, sol_time, sol_nonce} !== {1'b1, t, n}) begin
            n_fail++; $display("FAIL abort_next_sol: got %b %h %h want 1 %h %h",
                               sol_valid, sol_time, sol_nonce, t, n);
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [31:0] c, n;
        for (int j = 0; j < 8; j++) begin
            c = $urandom_range(1, 24);
            n = $urandom_range(0, 1) ? (32'hFFFF_FFFF - $urandom_range(0, 12)) : $urandom;
            start_job($urandom, n, c);
            for (int k = 1; k <= int'(c); k++)
                if ($urandom_range(0, 99) < 35) hit_at[k] = 1'b1;
            for (int i = 0; i < 200 && done_at < 0; i++) begin
                sol_ready = ($urandom_range(0, 2) == 0);
                step();
                n_cmp++;
                if (sol_valid !== m_sol_v || drop_cnt !== 8'(m_drop) ||
                    (m_sol_v && {sol_time, sol_nonce} !== m_sol)) begin
                    n_fail++;
                    $display("FAIL rand_slot: job %0d got v=%b %h%h drop=%0d want v=%b %h drop=%0d",
                             j, sol_valid, sol_time, sol_nonce, drop_cnt, m_sol_v, m_sol, m_drop);
                end
            end
            sol_ready = 1'b0;
            n_cmp++;
            if (done_at != int'(c) + PL || wen_cycles != int'(c) + PL - 1) begin
                n_fail++; $display("FAIL rand_len: job %0d got done_at %0d wen %0d want %0d %0d",
                                   j, done_at, wen_cycles, int'(c) + PL, int'(c) + PL - 1);
            end
        end
        sol_ready = 1'b1;
        step();
        sol_ready = 1'b0;
    endtask

    task automatic test_count0();
        bit ok;
        start_job($urandom, $urandom, 32'd0);
        while (since_load < 100) step();
        n_cmp++;
        if (dut.r_remaining !== TWO32 - 33'd99) begin
            n_fail++; $display("FAIL count0_remaining: got %h want %h",
                               dut.r_remaining, TWO32 - 33'd99);
        end
        n_cmp++;
        if ({hs_write_en, busy, job_done} !== 3'b110) begin
            n_fail++; $display("FAIL count0_running: got %b want 110",
                               {hs_write_en, busy, job_done});
        end
        force dut.r_remaining = 33'd3;
        step();
        release dut.r_remaining;
        wait_done(50, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++; $display("FAIL count0_finish: got no job_done want job_done");
        end
    endtask

    task automatic test_rst_drain();
        bit ok;
        start_job($urandom, $urandom, 32'd4);
        hit_at[1] = 1'b1;
        while (since_load < 7) step();
        n_cmp++;
        if ({sol_valid, hs_write_en} !== 2'b11) begin
            n_fail++; $display("FAIL rst_pre: got sol_valid/write_en %b want 11",
                               {sol_valid, hs_write_en});
        end
        #2 RST = 1'b0;
        #1;
        n_cmp++;
        if ({job_ready, hs_rst_n, hs_write_en, busy, job_done, sol_valid} !== 6'b100000) begin
            n_fail++; $display("FAIL rst_ctrl: got %b want 100000",
                               {job_ready, hs_rst_n, hs_write_en, busy, job_done, sol_valid});
        end
        n_cmp++;
        if ({drop_cnt, sol_time, sol_nonce, hs_nonce, hs_time} !== '0) begin
            n_fail++; $display("FAIL rst_data: got drop %0d sol %h%h hs_nonce %h want 0",
                               drop_cnt, sol_time, sol_nonce, hs_nonce);
        end
        @(negedge CLK);
        RST = 1'b1;
        m_sol_v = 1'b0;
        m_drop  = 0;
        start_job($urandom, $urandom, 32'd2);
        wait_done(20, ok);
        n_cmp++;
        if (!ok || done_at != 6 || sol_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_recover: got done_at %0d sol_valid %b want 6 0",
                               done_at, sol_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_drop();
        test_abort();
        test_random();
        test_count0();
        test_rst_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
